// File: rtl/uart.sv
// UART with independent 8N1 transmitter and 16x-oversampling receiver.
// TX bit timing comes from a free-running divider; RX uses a separate
// 16x tick and samples each bit near its centre.
module uart #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       wr_en,
  output logic       tx,
  output logic       tx_busy,
  input  logic       rx,
  output logic       rdy,
  input  logic       rdy_clr,
  output logic [7:0] dout
);

  localparam int TX_DIV = CLK_FREQ / BAUD;
  localparam int RX_DIV = CLK_FREQ / (16 * BAUD);
  localparam int TXW    = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;
  localparam int RXW    = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // ---------------------------------------------------------------- TX
  logic [TXW-1:0] tx_cnt;
  logic           tx_tick;
  state_t         tx_state, tx_state_n;
  logic [7:0]     tx_data, tx_data_n;
  logic [2:0]     tx_idx, tx_idx_n;

  assign tx_tick = (tx_cnt == TXW'(TX_DIV - 1));

  // Free-running TX bit-period divider
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) tx_cnt <= '0;
    else     tx_cnt <= tx_tick ? '0 : tx_cnt + 1'b1;
  end

  // TX state, latched byte and bit index
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      tx_state <= IDLE;
      tx_data  <= '0;
      tx_idx   <= '0;
    end else begin
      tx_state <= tx_state_n;
      tx_data  <= tx_data_n;
      tx_idx   <= tx_idx_n;
    end
  end

  // TX next state; tx is decoded from state so reset forces the line high at once
  always_comb begin
    tx_state_n = tx_state;
    tx_data_n  = tx_data;
    tx_idx_n   = tx_idx;
    tx         = 1'b1;
    tx_busy    = 1'b1;
    case (tx_state)
      IDLE: begin
        tx_busy = 1'b0;
        if (wr_en) begin
          tx_data_n  = din;
          tx_state_n = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (tx_tick) begin
          tx_state_n = DATA;
          tx_idx_n   = '0;
        end
      end
      DATA: begin
        tx = tx_data[tx_idx];
        if (tx_tick) begin
          tx_idx_n = tx_idx + 1'b1;
          if (tx_idx == 3'd7) tx_state_n = STOP;
        end
      end
      STOP: begin
        if (tx_tick) tx_state_n = IDLE;
      end
      default: tx_state_n = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- RX
  logic           rx_meta, rx_sync;
  logic [RXW-1:0] rx_div;
  logic           rx_tick;
  state_t         rx_state, rx_state_n;
  logic [3:0]     rx_cnt, rx_cnt_n;
  logic [2:0]     rx_idx, rx_idx_n;
  logic [7:0]     rx_shift, rx_shift_n;
  logic           rx_ferr, rx_ferr_n;
  logic           rx_done;

  assign rx_tick = (rx_div == RXW'(RX_DIV - 1));

  // Two-flop synchronizer for the asynchronous serial input
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Free-running 16x oversampling divider
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) rx_div <= '0;
    else     rx_div <= rx_tick ? '0 : rx_div + 1'b1;
  end

  // RX state, counters, shift register and the sticky output byte
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
      rx_ferr  <= 1'b0;
      dout     <= '0;
      rdy      <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_idx   <= rx_idx_n;
      rx_shift <= rx_shift_n;
      rx_ferr  <= rx_ferr_n;
      if (rx_done) begin
        dout <= rx_shift;
        rdy  <= 1'b1;
      end else if (rdy_clr) begin
        rdy <= 1'b0;
      end
    end
  end

  // RX next state; rx_ferr marks a bad stop bit so STOP waits for idle without loading
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_idx_n   = rx_idx;
    rx_shift_n = rx_shift;
    rx_ferr_n  = rx_ferr;
    rx_done    = 1'b0;
    if (rx_tick) begin
      case (rx_state)
        IDLE: begin
          if (!rx_sync) begin
            rx_state_n = START;
            rx_cnt_n   = '0;
          end
        end
        START: begin
          if (rx_sync) begin
            rx_state_n = IDLE;
            rx_cnt_n   = '0;
          end else if (rx_cnt == 4'd7) begin
            rx_state_n = DATA;
            rx_cnt_n   = '0;
            rx_idx_n   = '0;
          end else begin
            rx_cnt_n = rx_cnt + 1'b1;
          end
        end
        DATA: begin
          if (rx_cnt == 4'd15) begin
            rx_cnt_n   = '0;
            rx_shift_n = {rx_sync, rx_shift[7:1]};
            rx_idx_n   = rx_idx + 1'b1;
            if (rx_idx == 3'd7) rx_state_n = STOP;
          end else begin
            rx_cnt_n = rx_cnt + 1'b1;
          end
        end
        STOP: begin
          if (rx_ferr) begin
            if (rx_sync) begin
              rx_state_n = IDLE;
              rx_ferr_n  = 1'b0;
              rx_cnt_n   = '0;
            end
          end else if (rx_cnt == 4'd15) begin
            if (rx_sync) begin
              rx_done    = 1'b1;
              rx_state_n = IDLE;
              rx_cnt_n   = '0;
            end else begin
              rx_ferr_n = 1'b1;
            end
          end else begin
            rx_cnt_n = rx_cnt + 1'b1;
          end
        end
        default: rx_state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart.sv
// Scoreboard bench for uart: bytes expected at the receiver are queued when
// sent; a monitor pops and compares each time a new byte is presented.
module tb_uart;

  localparam int BIT = 434;

  logic       clk_50m = 1'b0;
  logic       rst     = 1'b1;
  logic [7:0] din     = '0;
  logic       wr_en   = 1'b0;
  logic       tx, tx_busy, rx, rdy;
  logic       rdy_clr = 1'b0;
  logic [7:0] dout;
  logic       loop    = 1'b1;
  logic       rx_drv  = 1'b1;

  assign rx = loop ? tx : rx_drv;

  uart #(.CLK_FREQ(50000000), .BAUD(115200)) dut (
    .clk_50m (clk_50m),
    .rst     (rst),
    .din     (din),
    .wr_en   (wr_en),
    .tx      (tx),
    .tx_busy (tx_busy),
    .rx      (rx),
    .rdy     (rdy),
    .rdy_clr (rdy_clr),
    .dout    (dout)
  );

  always #10 clk_50m = ~clk_50m;

  int cyc = 0;
  always @(posedge clk_50m) cyc <= cyc + 1;

  int         checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  int         event_cyc = 0;
  int         busy_falls = 0;
  logic       prev_rdy = 1'b0, prev_busy = 1'b0;
  logic [7:0] prev_dout = '0;

  task automatic check(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, expv, expv);
    end
  endtask

  // Monitor: a rising rdy or a changed dout with rdy high is a new byte
  always @(negedge clk_50m) begin
    if (!rst && rdy && (!prev_rdy || dout != prev_dout)) begin
      event_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rx_unexpected got 0x%0h expected no byte", dout);
      end else begin
        exp_b = exp_q.pop_front();
        if (dout !== exp_b) begin
          errors++;
          $display("FAIL rx_byte got 0x%0h expected 0x%0h", dout, exp_b);
        end
      end
    end
    if (prev_busy && !tx_busy) busy_falls++;
    prev_rdy  = rdy;
    prev_dout = dout;
    prev_busy = tx_busy;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_50m);
      #1;
    end
  endtask

  task automatic write(input logic [7:0] b, input bit expect_rx);
    @(posedge clk_50m);
    #1;
    din   = b;
    wr_en = 1'b1;
    if (expect_rx) exp_q.push_back(b);
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic wait_busy_low(output int n);
    n = 0;
    while (tx_busy && n < 20000) begin
      tick(1);
      n++;
    end
    if (tx_busy) check("busy_timeout", 1, 0);
  endtask

  task automatic wait_tx(input logic v, output int n);
    n = 0;
    while (tx !== v && n < 20000) begin
      tick(1);
      n++;
    end
    if (tx !== v) check("tx_timeout", 1, 0);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx_drv = 1'b0;
    tick(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      tick(BIT);
    end
    rx_drv = stop;
    tick(BIT);
  endtask

  task automatic clear_rdy();
    rdy_clr = 1'b1;
    tick(1);
    rdy_clr = 1'b0;
  endtask

  int n, bf, s1, s2, lat;
  logic [7:0] pats[2] = '{8'h00, 8'hFF};

  initial begin
    tick(5);
    check("rst_tx", tx, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_rdy", rdy, 0);
    check("rst_dout", dout, 0);
    rst = 1'b0;
    tick(5);

    // Loopback A5 with busy duration and sticky rdy
    write(8'hA5, 1);
    wait_busy_low(n);
    check("a5_busy_len_ok", int'(n >= 9*BIT + 1 && n <= 10*BIT), 1);
    check("a5_rdy_at_busy_fall", rdy, 1);
    tick(1000);
    check("a5_rdy_sticky", rdy, 1);
    check("a5_dout", dout, 8'hA5);
    clear_rdy();
    check("a5_rdy_cleared", rdy, 0);

    // Loopback all-zero and all-one bytes
    foreach (pats[i]) begin
      write(pats[i], 1);
      wait_busy_low(n);
      tick(50);
      check("pat_rdy", rdy, 1);
      clear_rdy();
    end

    // Line shape for 8'h01: start, one high bit, seven low bits, stop
    write(8'h01, 1);
    wait_tx(1'b1, n);
    check("p01_start_len_ok", int'(n >= 1 && n <= BIT), 1);
    wait_tx(1'b0, n);
    check("p01_bit0_len", n, BIT);
    wait_tx(1'b1, n);
    check("p01_bits1_7_len", n, 7*BIT);
    wait_busy_low(n);
    check("p01_stop_len", n, BIT);
    tick(50);
    clear_rdy();

    // Write while busy is ignored
    bf = busy_falls;
    write(8'hA5, 1);
    tick(100);
    write(8'h3C, 0);
    wait_busy_low(n);
    tick(4500);
    check("ign_busy_falls", busy_falls - bf, 1);
    check("ign_busy_low", tx_busy, 0);
    check("ign_dout", dout, 8'hA5);
    clear_rdy();

    // Asynchronous reset mid-transmission
    write(8'hC3, 0);
    tick(2000);
    #3 rst = 1'b1;
    #1;
    check("arst_tx", tx, 1);
    check("arst_busy", tx_busy, 0);
    tick(3);
    rst = 1'b0;
    tick(1000);
    check("arst_rdy", rdy, 0);
    write(8'h5A, 1);
    wait_busy_low(n);
    tick(50);
    check("arst_5a_rdy", rdy, 1);
    clear_rdy();

    // Direct rx: short glitch
    loop   = 1'b0;
    rx_drv = 1'b1;
    tick(100);
    rx_drv = 1'b0;
    tick(162);
    rx_drv = 1'b1;
    tick(4500);
    check("glitch_rdy", rdy, 0);

    // Framing error then recovery
    send_frame(8'h96, 1'b0);
    tick(2*BIT);
    rx_drv = 1'b1;
    tick(1000);
    check("ferr_rdy", rdy, 0);
    check("ferr_dout", dout, 8'h5A);
    exp_q.push_back(8'h69);
    send_frame(8'h69, 1'b1);
    tick(200);
    check("recov_rdy", rdy, 1);
    clear_rdy();

    // Completion coinciding with rdy_clr: latency measured, then replayed in phase
    tick(500);
    s1 = cyc;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    tick(200);
    lat = event_cyc - s1;
    check("coll_first_rdy", rdy, 1);
    while ((cyc - s1) % 27 != 0) tick(1);
    s2 = cyc;
    exp_q.push_back(8'hC5);
    fork
      send_frame(8'hC5, 1'b1);
      begin
        tick(lat - 1);
        rdy_clr = 1'b1;
        tick(1);
        rdy_clr = 1'b0;
      end
    join
    check("coll_event_cycle", event_cyc, s2 + lat);
    check("coll_rdy", rdy, 1);
    check("coll_dout", dout, 8'hC5);
    clear_rdy();
    check("coll_rdy_cleared", rdy, 0);

    tick(10);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
